// File: rtl/multiport_reg_file.sv
// Multi-ported integer register file with write-to-read bypass, hardwired r0
// and a per-register pending scoreboard for the multi-issue core.
module multiport_reg_file #(
    parameter  int XLEN     = 32,
    parameter  int NREG     = 32,
    parameter  int NR       = 2,
    parameter  int NW       = 2,
    parameter  int ZERO_REG = 1,
    parameter  int BYPASS   = 1,
    localparam int AW       = $clog2(NREG)
) (
    input  logic               clk,
    input  logic               rstd,
    input  logic [NR*AW-1:0]   rd_addr,
    output logic [NR*XLEN-1:0] rd_data,
    output logic [NR-1:0]      rd_pending,
    input  logic               iss_valid,
    input  logic [AW-1:0]      iss_addr,
    input  logic [NW-1:0]      wr_en,
    input  logic [NW*AW-1:0]   wr_addr,
    input  logic [NW*XLEN-1:0] wr_data,
    output logic               wr_conflict,
    output logic [AW:0]        pending_cnt
);

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_nxt;
    logic [AW:0]     pending_cnt_nxt;
    logic            conflict_nxt;

    logic [AW-1:0]   wa [NW];
    logic [XLEN-1:0] wd [NW];
    logic            wv [NW];

    // wv is a write that actually lands in storage (r0 writes are dropped).
    always_comb begin
        for (int p = 0; p < NW; p++) begin
            wa[p] = wr_addr[p*AW +: AW];
            wd[p] = wr_data[p*XLEN +: XLEN];
            wv[p] = wr_en[p] && !((ZERO_REG != 0) && (wr_addr[p*AW +: AW] == '0));
        end
    end

    always_comb begin
        conflict_nxt = 1'b0;
        for (int i = 0; i < NW; i++) begin
            for (int j = i + 1; j < NW; j++) begin
                if (wv[i] && wv[j] && (wa[i] == wa[j])) begin
                    conflict_nxt = 1'b1;
                end
            end
        end
    end

    // Clears first, then the issue set, so a new producer beats a same-cycle writeback.
    always_comb begin
        pending_nxt = pending;
        for (int p = 0; p < NW; p++) begin
            if (wr_en[p]) begin
                pending_nxt[wa[p]] = 1'b0;
            end
        end
        if (iss_valid) begin
            pending_nxt[iss_addr] = 1'b1;
        end
        if (ZERO_REG != 0) begin
            pending_nxt[0] = 1'b0;
        end
    end

    assign pending_cnt_nxt = (AW+1)'($countones(pending_nxt));

    // Ascending port order makes the highest-index port the last (winning) write.
    always_ff @(posedge clk) begin
        if (rstd) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= '0;
            end
        end else begin
            for (int p = 0; p < NW; p++) begin
                if (wv[p]) begin
                    regs[wa[p]] <= wd[p];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstd) begin
            pending     <= '0;
            wr_conflict <= 1'b0;
            pending_cnt <= '0;
        end else begin
            pending     <= pending_nxt;
            wr_conflict <= conflict_nxt;
            pending_cnt <= pending_cnt_nxt;
        end
    end

    always_comb begin
        rd_data    = '0;
        rd_pending = '0;
        for (int i = 0; i < NR; i++) begin
            rd_data[i*XLEN +: XLEN] = regs[rd_addr[i*AW +: AW]];
            rd_pending[i]           = pending[rd_addr[i*AW +: AW]];
            if (BYPASS != 0) begin
                for (int p = 0; p < NW; p++) begin
                    if (wr_en[p] && (wa[p] == rd_addr[i*AW +: AW])) begin
                        rd_data[i*XLEN +: XLEN] = wd[p];
                        rd_pending[i]           = 1'b0;
                    end
                end
            end
            if ((ZERO_REG != 0) && (rd_addr[i*AW +: AW] == '0)) begin
                rd_data[i*XLEN +: XLEN] = '0;
                rd_pending[i]           = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_multiport_reg_file.sv
// Bench for multiport_reg_file: three configurations driven from shared
// stimulus and checked against a reference model through a scoreboard queue.
module tb_multiport_reg_file;

    localparam int AW = 5;
    localparam int NI = 3;

    logic            clk;
    logic            rstd;
    logic [4*AW-1:0] ra;
    logic [3:0]      we;
    logic [4*AW-1:0] wa;
    logic [127:0]    wd;
    logic            iss_valid;
    logic [AW-1:0]   iss_addr;

    logic [63:0]  rd_data_a;
    logic [1:0]   rd_pending_a;
    logic         conf_a;
    logic [AW:0]  cnt_a;
    logic [127:0] rd_data_b;
    logic [3:0]   rd_pending_b;
    logic         conf_b;
    logic [AW:0]  cnt_b;
    logic [31:0]  rd_data_c;
    logic [0:0]   rd_pending_c;
    logic         conf_c;
    logic [AW:0]  cnt_c;

    int cfg_nr  [NI] = '{2, 4, 1};
    int cfg_nw  [NI] = '{2, 4, 1};
    int cfg_byp [NI] = '{1, 0, 1};

    logic [31:0] m_regs [NI][32];
    logic        m_pend [NI][32];
    logic        m_conf [NI];
    int          m_cnt  [NI];

    typedef struct {
        string       tag;
        int          inst;
        int          kind;
        int          port;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_vec;
    int   n_miss;

    multiport_reg_file #(.XLEN(32), .NREG(32), .NR(2), .NW(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rstd(rstd), .rd_addr(ra[2*AW-1:0]), .rd_data(rd_data_a),
        .rd_pending(rd_pending_a), .iss_valid(iss_valid), .iss_addr(iss_addr),
        .wr_en(we[1:0]), .wr_addr(wa[2*AW-1:0]), .wr_data(wd[63:0]),
        .wr_conflict(conf_a), .pending_cnt(cnt_a)
    );

    multiport_reg_file #(.XLEN(32), .NREG(32), .NR(4), .NW(4), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clk(clk), .rstd(rstd), .rd_addr(ra), .rd_data(rd_data_b),
        .rd_pending(rd_pending_b), .iss_valid(iss_valid), .iss_addr(iss_addr),
        .wr_en(we), .wr_addr(wa), .wr_data(wd),
        .wr_conflict(conf_b), .pending_cnt(cnt_b)
    );

    multiport_reg_file #(.XLEN(32), .NREG(32), .NR(1), .NW(1), .ZERO_REG(1), .BYPASS(1)) dut_c (
        .clk(clk), .rstd(rstd), .rd_addr(ra[AW-1:0]), .rd_data(rd_data_c),
        .rd_pending(rd_pending_c), .iss_valid(iss_valid), .iss_addr(iss_addr),
        .wr_en(we[0:0]), .wr_addr(wa[AW-1:0]), .wr_data(wd[31:0]),
        .wr_conflict(conf_c), .pending_cnt(cnt_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [AW-1:0] rd_a(int p);
        return ra[p*AW +: AW];
    endfunction

    function automatic logic [AW-1:0] wr_a(int p);
        return wa[p*AW +: AW];
    endfunction

    function automatic logic [31:0] wr_d(int p);
        return wd[p*32 +: 32];
    endfunction

    function automatic logic [31:0] model_data(int k, int p);
        logic [31:0] v;
        if (rd_a(p) == '0) return 32'h0;
        v = m_regs[k][rd_a(p)];
        if (cfg_byp[k] != 0) begin
            for (int j = 0; j < cfg_nw[k]; j++) begin
                if (we[j] && (wr_a(j) == rd_a(p))) v = wr_d(j);
            end
        end
        return v;
    endfunction

    function automatic logic model_pend(int k, int p);
        logic v;
        if (rd_a(p) == '0) return 1'b0;
        v = m_pend[k][rd_a(p)];
        if (cfg_byp[k] != 0) begin
            for (int j = 0; j < cfg_nw[k]; j++) begin
                if (we[j] && (wr_a(j) == rd_a(p))) v = 1'b0;
            end
        end
        return v;
    endfunction

    function automatic logic [31:0] get_actual(int k, int kind, int p);
        case (k)
            0: case (kind)
                   0: return rd_data_a[p*32 +: 32];
                   1: return 32'(rd_pending_a[p]);
                   2: return 32'(conf_a);
                   default: return 32'(cnt_a);
               endcase
            1: case (kind)
                   0: return rd_data_b[p*32 +: 32];
                   1: return 32'(rd_pending_b[p]);
                   2: return 32'(conf_b);
                   default: return 32'(cnt_b);
               endcase
            default: case (kind)
                   0: return rd_data_c;
                   1: return 32'(rd_pending_c[0]);
                   2: return 32'(conf_c);
                   default: return 32'(cnt_c);
               endcase
        endcase
    endfunction

    // Advances the reference model by one posedge using the inputs held across it.
    task automatic model_edge();
        for (int k = 0; k < NI; k++) begin
            if (rstd) begin
                for (int r = 0; r < 32; r++) begin
                    m_regs[k][r] = 32'h0;
                    m_pend[k][r] = 1'b0;
                end
                m_conf[k] = 1'b0;
                m_cnt[k]  = 0;
            end else begin
                m_conf[k] = 1'b0;
                for (int i = 0; i < cfg_nw[k]; i++)
                    for (int j = i + 1; j < cfg_nw[k]; j++)
                        if (we[i] && we[j] && wr_a(i) == wr_a(j) && wr_a(i) != '0) m_conf[k] = 1'b1;
                for (int j = 0; j < cfg_nw[k]; j++) begin
                    if (we[j] && wr_a(j) != '0) m_regs[k][wr_a(j)] = wr_d(j);
                    if (we[j]) m_pend[k][wr_a(j)] = 1'b0;
                end
                if (iss_valid && iss_addr != '0) m_pend[k][iss_addr] = 1'b1;
                m_cnt[k] = 0;
                for (int r = 0; r < 32; r++) if (m_pend[k][r]) m_cnt[k]++;
            end
        end
    endtask

    task automatic clockEdge();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic push(string tag, int k, int kind, int p, logic [31:0] v);
        exp_t e;
        e.tag  = tag;
        e.inst = k;
        e.kind = kind;
        e.port = p;
        e.exp  = v;
        sb.push_back(e);
    endtask

    // Settles the freshly driven inputs and queues the model's view of every output.
    task automatic applyStimulus();
        #1;
        for (int k = 0; k < NI; k++) begin
            for (int p = 0; p < cfg_nr[k]; p++) begin
                push($sformatf("i%0d_rd_data%0d", k, p), k, 0, p, model_data(k, p));
                push($sformatf("i%0d_rd_pending%0d", k, p), k, 1, p, 32'(model_pend(k, p)));
            end
            push($sformatf("i%0d_wr_conflict", k), k, 2, 0, 32'(m_conf[k]));
            push($sformatf("i%0d_pending_cnt", k), k, 3, 0, 32'(m_cnt[k]));
        end
    endtask

    task automatic checkOutput();
        exp_t        e;
        logic [31:0] act;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            act = get_actual(e.inst, e.kind, e.port);
            n_vec++;
            assert (act === e.exp) else begin
                n_miss++;
                $error("[TB] FAIL %s: observed %h expected %h", e.tag, act, e.exp);
            end
        end
    endtask

    task automatic idle();
        we        = '0;
        iss_valid = 1'b0;
    endtask

    task automatic set_rd(int p, int a);
        ra[p*AW +: AW] = AW'(a);
    endtask

    task automatic set_wr(int p, int a, logic [31:0] d);
        we[p]          = 1'b1;
        wa[p*AW +: AW] = AW'(a);
        wd[p*32 +: 32] = d;
    endtask

    task automatic issue(int a);
        iss_valid = 1'b1;
        iss_addr  = AW'(a);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 1) == 0) return AW'($urandom_range(0, 7));
        return AW'($urandom_range(0, 31));
    endfunction

    initial begin
        n_vec    = 0;
        n_miss   = 0;
        rstd     = 1'b1;
        ra       = '0;
        wa       = '0;
        wd       = '0;
        iss_addr = '0;
        idle();
        clockEdge();
        clockEdge();
        rstd = 1'b0;

        $display("[TB] reset state on every register");
        for (int a = 0; a < 32; a++) begin
            for (int p = 0; p < 4; p++) set_rd(p, a);
            applyStimulus();
            for (int p = 0; p < 2; p++) begin
                push("reset_rd_data", 0, 0, p, 32'h0);
                push("reset_rd_pending", 0, 1, p, 32'h0);
            end
            push("reset_pending_cnt", 1, 3, 0, 32'h0);
            checkOutput();
            clockEdge();
        end

        $display("[TB] write r5 with same-cycle read");
        set_wr(0, 5, 32'hDEADBEEF);
        set_rd(0, 5);
        applyStimulus();
        push("bypass_r5", 0, 0, 0, 32'hDEADBEEF);
        push("nobypass_r5", 1, 0, 0, 32'h0);
        checkOutput();
        clockEdge();
        idle();
        applyStimulus();
        push("nobypass_r5_next", 1, 0, 0, 32'hDEADBEEF);
        push("stored_r5", 0, 0, 0, 32'hDEADBEEF);
        checkOutput();

        $display("[TB] colliding writes");
        set_wr(0, 7, 32'h11);
        set_wr(1, 7, 32'h22);
        set_rd(0, 7);
        applyStimulus();
        push("bypass_r7_winner", 0, 0, 0, 32'h22);
        checkOutput();
        clockEdge();
        idle();
        applyStimulus();
        push("r7_winner", 0, 0, 0, 32'h22);
        push("conflict_set", 0, 2, 0, 32'h1);
        checkOutput();
        clockEdge();
        set_wr(0, 0, 32'h33);
        set_wr(1, 0, 32'h44);
        set_rd(0, 0);
        applyStimulus();
        push("conflict_cleared", 0, 2, 0, 32'h0);
        push("r0_bypass_zero", 0, 0, 0, 32'h0);
        checkOutput();
        clockEdge();
        idle();
        applyStimulus();
        push("r0_conflict", 0, 2, 0, 32'h0);
        push("r0_zero", 0, 0, 0, 32'h0);
        checkOutput();

        $display("[TB] scoreboard issue and writeback");
        issue(3);
        clockEdge();
        issue(9);
        clockEdge();
        idle();
        set_rd(0, 3);
        set_rd(1, 9);
        applyStimulus();
        push("pend_r3", 0, 1, 0, 32'h1);
        push("pend_r9", 0, 1, 1, 32'h1);
        push("pend_cnt2", 0, 3, 0, 32'h2);
        checkOutput();
        set_wr(0, 3, 32'h1234);
        applyStimulus();
        push("pend_r3_bypassed", 0, 1, 0, 32'h0);
        push("pend_r3_nobypass", 1, 1, 0, 32'h1);
        checkOutput();
        clockEdge();
        idle();
        applyStimulus();
        push("pend_cnt1", 0, 3, 0, 32'h1);
        checkOutput();
        clockEdge();
        issue(9);
        set_wr(0, 9, 32'h5678);
        clockEdge();
        idle();
        applyStimulus();
        push("pend_r9_set_wins", 0, 1, 1, 32'h1);
        push("pend_cnt_after_set_wins", 0, 3, 0, 32'h1);
        checkOutput();

        $display("[TB] reset during active writes");
        for (int i = 0; i < 10; i++) begin
            idle();
            issue(10 + i);
            set_wr(0, 20 + i, 32'(i + 100));
            clockEdge();
        end
        idle();
        applyStimulus();
        push("pend_cnt_before_reset", 0, 3, 0, 32'd11);
        checkOutput();
        rstd = 1'b1;
        set_wr(0, 20, 32'hAAAA);
        set_wr(1, 20, 32'hBBBB);
        issue(5);
        clockEdge();
        rstd = 1'b0;
        idle();
        set_rd(0, 20);
        set_rd(1, 10);
        applyStimulus();
        push("post_reset_r20", 0, 0, 0, 32'h0);
        push("post_reset_pend_r10", 0, 1, 1, 32'h0);
        push("post_reset_conflict", 0, 2, 0, 32'h0);
        push("post_reset_cnt", 0, 3, 0, 32'h0);
        checkOutput();

        $display("[TB] random traffic");
        for (int c = 0; c < 10000; c++) begin
            for (int p = 0; p < 4; p++) begin
                ra[p*AW +: AW] = rand_addr();
                wa[p*AW +: AW] = rand_addr();
                wd[p*32 +: 32] = $urandom;
            end
            we        = 4'($urandom & $urandom);
            iss_valid = 1'($urandom_range(0, 1));
            iss_addr  = rand_addr();
            rstd      = ($urandom_range(0, 499) == 0);
            applyStimulus();
            checkOutput();
            clockEdge();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
